// File: rtl/pow_engine.sv
// Sequential a^b unit: LSB-first square-and-multiply on one shared radix-2 shift-add multiplier.
// Optional overflow tracking with a double-width product is enabled by defining POW_OVF_DETECT_EN.
module pow_engine #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 256
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [IN_W-1:0]  i_a,
  input  logic [IN_W-1:0]  i_b,
  output logic [OUT_W-1:0] o_out,
  output logic             o_ready,
  output logic             o_done,
  output logic             o_ovf
);

`ifdef POW_OVF_DETECT_EN
  localparam int PW = 2 * OUT_W;
`else
  localparam int PW = OUT_W;
`endif

  // state | meaning: IDLE wait start | CHECK pick step | MUL_R acc*=base | MUL_B base*=base | SHIFT exp>>=1 | FINISH publish
  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MUL_R,
    S_MUL_B,
    S_SHIFT,
    S_FINISH
  } state_t;

  state_t           r_state;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] r_base;
  logic [IN_W-1:0]  r_exp;
  logic [PW-1:0]    r_md;
  logic [OUT_W-1:0] r_mr;
  logic [PW-1:0]    r_p;
  logic             r_phase;
  logic [OUT_W-1:0] r_out;
  logic             r_ready;
  logic             r_done;

  logic [OUT_W-1:0] w_a_ext;
  logic [PW-1:0]    w_p_next;
  logic [OUT_W-1:0] w_mr_next;
  logic             w_last;
  logic             w_exp_hi_zero;
  logic             w_upper_nz;

  assign w_a_ext       = OUT_W'(i_a);
  assign w_p_next      = r_mr[0] ? (r_p + r_md) : r_p;
  assign w_mr_next     = r_mr >> 1;
  assign w_last        = (w_mr_next == '0);
  assign w_exp_hi_zero = ((r_exp >> 1) == '0);

`ifdef POW_OVF_DETECT_EN
  logic r_ovf;
  logic r_base_ovf;
  assign w_upper_nz = |w_p_next[PW-1:OUT_W];
  assign o_ovf      = r_ovf;
`else
  assign w_upper_nz = 1'b0;
  assign o_ovf      = 1'b0;
`endif

  assign o_out   = r_out;
  assign o_ready = r_ready;
  assign o_done  = r_done;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_base     <= '0;
      r_exp      <= '0;
      r_md       <= '0;
      r_mr       <= '0;
      r_p        <= '0;
      r_phase    <= 1'b0;
      r_out      <= '0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
`ifdef POW_OVF_DETECT_EN
      r_ovf      <= 1'b0;
      r_base_ovf <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc      <= OUT_W'(1);
            r_base     <= w_a_ext;
            r_exp      <= i_b;
`ifdef POW_OVF_DETECT_EN
            r_ovf      <= 1'b0;
            r_base_ovf <= 1'b0;
`endif
            r_ready    <= 1'b0;
            r_state    <= S_CHECK;
          end
        end

        S_CHECK: begin
          r_phase <= 1'b0;
          if (r_exp == '0) begin
            r_state <= S_FINISH;
          end else if (r_exp[0]) begin
            r_state <= S_MUL_R;
`ifdef POW_OVF_DETECT_EN
            // A base that already wrapped poisons any product that uses it.
            if (r_base_ovf) r_ovf <= 1'b1;
`endif
          end else begin
            r_state <= S_MUL_B;
          end
        end

        S_MUL_R: begin
          if (!r_phase) begin
            r_p     <= '0;
            r_md    <= PW'(r_acc);
            r_mr    <= r_base;
            r_phase <= 1'b1;
          end else begin
            r_p  <= w_p_next;
            r_md <= r_md << 1;
            r_mr <= w_mr_next;
            if (w_last) begin
              r_acc   <= w_p_next[OUT_W-1:0];
`ifdef POW_OVF_DETECT_EN
              if (w_upper_nz) r_ovf <= 1'b1;
`endif
              r_phase <= 1'b0;
              r_state <= S_MUL_B;
            end
          end
        end

        S_MUL_B: begin
          if (!r_phase) begin
            // Last exponent bit consumed: the square would never be used.
            if (w_exp_hi_zero) begin
              r_state <= S_SHIFT;
            end else begin
              r_p     <= '0;
              r_md    <= PW'(r_base);
              r_mr    <= r_base;
              r_phase <= 1'b1;
            end
          end else begin
            r_p  <= w_p_next;
            r_md <= r_md << 1;
            r_mr <= w_mr_next;
            if (w_last) begin
              r_base  <= w_p_next[OUT_W-1:0];
`ifdef POW_OVF_DETECT_EN
              if (w_upper_nz) r_base_ovf <= 1'b1;
`endif
              r_phase <= 1'b0;
              r_state <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          r_exp   <= r_exp >> 1;
          r_state <= S_CHECK;
        end

        S_FINISH: begin
          r_out   <= r_acc;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pow_engine.sv
// Directed bench for pow_engine: a default 64/256 instance and an 8/16 instance,
// checked against an arithmetic power model (repeated multiplication with overflow flag).
module tb_pow_engine;
  localparam int IN_W    = 64;
  localparam int OUT_W   = 256;
  localparam int S_IN    = 8;
  localparam int S_OUT   = 16;
  localparam int BOUND   = 2 + IN_W * (3 + 2 * (OUT_W + 1));
  localparam int S_BOUND = 2 + S_IN * (3 + 2 * (S_OUT + 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic             start = 1'b0;
  logic [IN_W-1:0]  a = '0;
  logic [IN_W-1:0]  b = '0;
  logic [OUT_W-1:0] out;
  logic             ready, done, ovf;

  logic             s_start = 1'b0;
  logic [S_IN-1:0]  s_a = '0;
  logic [S_IN-1:0]  s_b = '0;
  logic [S_OUT-1:0] s_out;
  logic             s_ready, s_done, s_ovf;

  always #5 clk = ~clk;

  pow_engine #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
    .o_out(out), .o_ready(ready), .o_done(done), .o_ovf(ovf)
  );

  pow_engine #(.IN_W(S_IN), .OUT_W(S_OUT)) dut_s (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(s_start), .i_a(s_a), .i_b(s_b),
    .o_out(s_out), .o_ready(s_ready), .o_done(s_done), .o_ovf(s_ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // out = a^b mod 2^ow, ovf = (a^b >= 2^ow) when overflow tracking is built in
  function automatic void model(input int ow, input logic [63:0] ma, input logic [63:0] mb,
                                output logic [255:0] r, output logic o);
    logic [511:0] acc;
    logic [511:0] mask;
    mask = {512{1'b1}} >> (512 - ow);
    acc  = 512'd1;
    o    = 1'b0;
    if (ma == 64'd0) begin
      acc = (mb == 64'd0) ? 512'd1 : 512'd0;
    end else if (ma != 64'd1) begin
      for (longint unsigned i = 0; i < mb; i++) begin
        acc = acc * {448'd0, ma};
        if ((acc & ~mask) != 512'd0) o = 1'b1;
        acc = acc & mask;
      end
    end
    r = acc[255:0];
`ifndef POW_OVF_DETECT_EN
    o = 1'b0;
`endif
  endfunction

  logic [255:0] pend_out = '0, hold_out = '0, s_pend_out = '0, s_hold_out = '0;
  logic         pend_ovf = 1'b0, hold_ovf = 1'b0, s_pend_ovf = 1'b0, s_hold_ovf = 1'b0;
  bit           valid = 1'b0, s_valid = 1'b0;
  int           done_cnt = 0, s_done_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      valid   = 1'b0;
      s_valid = 1'b0;
    end else begin
      if (!ready) valid = 1'b0;
      if (done) begin
        done_cnt++;
        check("done_with_ready", 256'(ready), 256'd1);
        check("out", 256'(out), pend_out);
        check("ovf", 256'(ovf), 256'(pend_ovf));
        hold_out = pend_out;
        hold_ovf = pend_ovf;
        valid    = 1'b1;
      end else if (ready && valid) begin
        check("out_hold", 256'(out), hold_out);
        check("ovf_hold", 256'(ovf), 256'(hold_ovf));
      end

      if (!s_ready) s_valid = 1'b0;
      if (s_done) begin
        s_done_cnt++;
        check("s_done_with_ready", 256'(s_ready), 256'd1);
        check("s_out", 256'(s_out), s_pend_out);
        check("s_ovf", 256'(s_ovf), 256'(s_pend_ovf));
        s_hold_out = s_pend_out;
        s_hold_ovf = s_pend_ovf;
        s_valid    = 1'b1;
      end else if (s_ready && s_valid) begin
        check("s_out_hold", 256'(s_out), s_hold_out);
        check("s_ovf_hold", 256'(s_ovf), 256'(s_hold_ovf));
      end
    end
  end

  // exp_cyc >= 0 pins the exact edge count from the accepting edge to done; otherwise the worst-case bound applies
  task automatic run(input bit sm, input logic [63:0] ta, input logic [63:0] tbv,
                     input int exp_cyc, input bit inject, input string nm);
    logic [255:0] r;
    logic         o;
    int           cyc;
    int           d0;
    int           bound;
    model(sm ? S_OUT : OUT_W, ta, tbv, r, o);
    bound = sm ? S_BOUND : BOUND;
    cyc = 0;
    while (!(sm ? s_ready : ready) && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check({nm, "_ready_before"}, 256'(sm ? s_ready : ready), 256'd1);
    @(negedge clk);
    if (sm) begin
      s_pend_out = r; s_pend_ovf = o; d0 = s_done_cnt;
      s_a = ta[S_IN-1:0]; s_b = tbv[S_IN-1:0]; s_start = 1'b1;
    end else begin
      pend_out = r; pend_ovf = o; d0 = done_cnt;
      a = ta; b = tbv; start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0; s_start = 1'b0;
    cyc = 0;
    while (!(sm ? s_done : done) && cyc < bound + 5) begin
      if (inject && cyc == 10) begin a = 64'd9; b = 64'd9; start = 1'b1; end
      if (inject && cyc == 11) start = 1'b0;
      @(posedge clk); #1; cyc++;
    end
    start = 1'b0;
    check({nm, "_done_seen"}, 256'(sm ? s_done : done), 256'd1);
    if (exp_cyc >= 0) check({nm, "_latency"}, 256'(cyc), 256'(exp_cyc));
    else              check({nm, "_within_bound"}, 256'(cyc <= bound), 256'd1);
    @(posedge clk); #1;
    check({nm, "_done_clears"}, 256'(sm ? s_done : done), 256'd0);
    check({nm, "_one_done"}, 256'((sm ? s_done_cnt : done_cnt) - d0), 256'd1);
    if (inject) begin
      repeat (3) begin
        @(posedge clk); #1;
        check({nm, "_stays_idle"}, 256'(ready), 256'd1);
      end
    end
  endtask

  initial begin
    logic [255:0] mr;
    logic         mo;
    int           d0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 256'(ready), 256'd1);
    check("rst_out", 256'(out), 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_ovf", 256'(ovf), 256'd0);
    check("rst_s_ready", 256'(s_ready), 256'd1);
    @(negedge clk);
    rst_n = 1'b1;

    model(OUT_W, 64'd2, 64'd3, mr, mo);
    check("model_2_3", mr, 256'd8);
    model(OUT_W, 64'd7, 64'd13, mr, mo);
    check("model_7_13", mr, 256'd96889010407);
    model(S_OUT, 64'd255, 64'd2, mr, mo);
    check("model_255_2_w16", mr, 256'd65025);
    model(S_OUT, 64'd2, 64'd16, mr, mo);
    check("model_2_16_w16", mr, 256'd0);

    run(1'b0, 64'd5, 64'd3, -1, 1'b0, "p5_3");

    // abort 3^40 part-way with an asynchronous reset between edges
    @(negedge clk);
    a = 64'd3; b = 64'd40; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done_cnt;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 256'(ready), 256'd1);
    check("abort_out", 256'(out), 256'd0);
    check("abort_ovf", 256'(ovf), 256'd0);
    check("abort_done", 256'(done), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", 256'(done_cnt - d0), 256'd0);
    check("abort_idle", 256'(ready), 256'd1);

    run(1'b0, 64'd2, 64'd3, -1, 1'b0, "p2_3");
    check("p2_3_lit", 256'(out), 256'd8);

    run(1'b0, 64'd2, 64'd64, -1, 1'b0, "p2_64");
    check("p2_64_lit", 256'(out), 256'd18446744073709551616);
    check("p2_64_ovf_lit", 256'(ovf), 256'd0);

    run(1'b0, 64'd0, 64'd0, 2, 1'b0, "p0_0");
    check("p0_0_lit", 256'(out), 256'd1);
    run(1'b0, 64'd5, 64'd0, 2, 1'b0, "p5_0");
    run(1'b0, 64'd0, 64'd7, -1, 1'b0, "p0_7");
    check("p0_7_lit", 256'(out), 256'd0);
    run(1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, -1, 1'b0, "p1_max");
    check("p1_max_lit", 256'(out), 256'd1);

    run(1'b0, 64'd2, 64'd256, -1, 1'b0, "p2_256");
    check("p2_256_out_lit", 256'(out), 256'd0);
`ifdef POW_OVF_DETECT_EN
    check("p2_256_ovf_lit", 256'(ovf), 256'd1);
`else
    check("p2_256_ovf_lit", 256'(ovf), 256'd0);
`endif
    run(1'b0, 64'd3, 64'd161, -1, 1'b0, "p3_161");
    check("p3_161_ovf_lit", 256'(ovf), 256'd0);

    run(1'b0, 64'd7, 64'd13, -1, 1'b1, "busy_7_13");
    check("busy_7_13_lit", 256'(out), 256'd96889010407);

    run(1'b1, 64'd255, 64'd2, -1, 1'b0, "s255_2");
    check("s255_2_lit", 256'(s_out), 256'd65025);
    run(1'b1, 64'd2, 64'd16, -1, 1'b0, "s2_16");
    check("s2_16_out_lit", 256'(s_out), 256'd0);
`ifdef POW_OVF_DETECT_EN
    check("s2_16_ovf_lit", 256'(s_ovf), 256'd1);
`else
    check("s2_16_ovf_lit", 256'(s_ovf), 256'd0);
`endif
    run(1'b1, 64'd3, 64'd0, 2, 1'b0, "s3_0");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
